conv2d_3x3_param: RTL

//  Next-gen 3x3 2D convolution: window generator plus MAC core in one block.

---
 rtl/conv2d_3x3_param_pkg.sv | 57 +++++
 rtl/conv2d_3x3_param_window.sv | 108 ++++++++++
 rtl/conv2d_3x3_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conv2d_3x3_param_pkg.sv
//------------------------------------------------------------------------------
// Module   : conv_pkg
// Brief    : Shared types, constants and arithmetic helpers for the 3x3
//            convolution block (state encoding, tap count, bias address,
//            accumulator sizing and round/saturate).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  // Frame-tracking states, encoded on an explicit 2-bit vector
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } conv_state_e;

  localparam int NUM_TAPS  = 9;
  localparam int BIAS_ADDR = 9;

  // Working width of the round/saturate helper; wide enough for any
  // accumulator of a DATA_WIDTH up to 30 bits.
  localparam int SAT_W = 64;

  // Accumulator width: full product plus 4 guard bits for the 9-term sum
  function automatic int ACC_WIDTH(input int dw);
    return 2 * dw + 4;
  endfunction

  // Round half-up at the FRAC position, shift back to Q format and clamp to
  // the signed dw-bit range. Caller truncates the result to dw bits.
  function automatic logic signed [SAT_W-1:0] round_sat(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      dw
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] res;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    res = (acc + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    if (res > hi) begin
      res = hi;
    end else if (res < lo) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_3x3_param_window.sv
//------------------------------------------------------------------------------
// Module   : conv_window_3x3
// Brief    : Raster-scan window generator: column/row counters, two line
//            buffers, 3x3 window register and the per-pixel emit decision
//            (including stride and last-result-of-frame tagging).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_3x3
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int STRIDE     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                i_pixel,
  input  logic                                 i_valid,
  output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  o_taps,
  output logic                                 o_valid,
  output logic                                 o_last,
  output logic                                 o_frame_end,
  output logic                                 o_row_ge2
);

  localparam int c_col_w = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int c_row_w = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [c_col_w-1:0] c_col_max  = c_col_w'(IMG_WIDTH - 1);
  localparam logic [c_row_w-1:0] c_row_max  = c_row_w'(IMG_HEIGHT - 1);
  // Position of the final emitted window; with stride 2 on an even-sized
  // image this is not the last pixel of the frame.
  localparam logic [c_col_w-1:0] c_col_lastw = c_col_w'(2 + ((IMG_WIDTH  - 3) / STRIDE) * STRIDE);
  localparam logic [c_row_w-1:0] c_row_lastw = c_row_w'(2 + ((IMG_HEIGHT - 3) / STRIDE) * STRIDE);

  if (!(STRIDE == 1 || STRIDE == 2)) begin : g_bad_stride
    $error("conv_window_3x3: STRIDE must be 1 or 2");
  end

  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;
  logic [DATA_WIDTH-1:0] r_lb_a [IMG_WIDTH];  // row - 1
  logic [DATA_WIDTH-1:0] r_lb_b [IMG_WIDTH];  // row - 2
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] r_win;
  logic                  w_col_ok;
  logic                  w_row_ok;
  logic                  w_emit;

  // Stride 2 keeps windows whose bottom-right corner has an even index
  assign w_col_ok    = (r_col >= c_col_w'(2)) && ((STRIDE == 1) || !r_col[0]);
  assign w_row_ok    = (r_row >= c_row_w'(2)) && ((STRIDE == 1) || !r_row[0]);
  assign w_emit      = i_valid && w_col_ok && w_row_ok;
  assign o_frame_end = i_valid && (r_col == c_col_max) && (r_row == c_row_max);
  assign o_row_ge2   = (r_row >= c_row_w'(2));
  assign o_taps      = r_win;

  // Raster position of the next accepted pixel; wraps to 0,0 after the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (r_col == c_col_max) begin
        r_col <= '0;
        r_row <= (r_row == c_row_max) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers shift one row down per accepted pixel; contents survive reset
  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_lb_b[r_col] <= r_lb_a[r_col];
      r_lb_a[r_col] <= i_pixel;
    end
  end

  // Window shifts left and takes the new column (row-2, row-1, current pixel)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= w_emit;
      o_last  <= w_emit && (r_col == c_col_lastw) && (r_row == c_row_lastw);
      if (i_valid) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_lb_b[r_col];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= r_lb_a[r_col];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= i_pixel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv2d_3x3_param.sv
//------------------------------------------------------------------------------
// Module   : conv2d_3x3_param
// Brief    : 3x3 signed fixed-point convolution with runtime weights/bias,
//            stride 1 or 2 and frame tracking. Pixel accepted at edge N gives
//            its result at edge N+3. Optional macro CONV2D_RELU_EN clamps
//            negative results to zero in the output stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv2d_3x3_param
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic [DATA_WIDTH-1:0] Weight_In,
  input  logic [3:0]            Weight_Addr,
  input  logic                  Weight_Wr,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done,
  output logic                  Busy
);

  localparam int c_acc_w  = ACC_WIDTH(DATA_WIDTH);
  localparam int c_prod_w = 2 * DATA_WIDTH;

  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] w_taps;
  logic                    w_win_valid;
  logic                    w_win_last;
  logic                    w_frame_end;
  logic                    w_row_ge2;

  logic signed [DATA_WIDTH-1:0] r_weights [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] r_bias;
  logic signed [c_prod_w-1:0]   r_prod [NUM_TAPS];
  logic                         r_v2;
  logic                         r_l2;
  logic signed [c_acc_w-1:0]    r_acc;
  logic                         r_v3;
  logic                         r_l3;
  logic signed [c_acc_w-1:0]    w_sum;
  logic [DATA_WIDTH-1:0]        w_res;
  logic [DATA_WIDTH-1:0]        w_out;

  conv_state_e r_state;
  conv_state_e w_next;
  logic [1:0]  r_drain_cnt;
  logic        r_pending;

  conv_window_3x3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .STRIDE     (STRIDE)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .i_pixel     (Data_In),
    .i_valid     (Valid_In),
    .o_taps      (w_taps),
    .o_valid     (w_win_valid),
    .o_last      (w_win_last),
    .o_frame_end (w_frame_end),
    .o_row_ge2   (w_row_ge2)
  );

  assign Busy = (r_state != IDLE);

  // Weight/bias file; writes only land between frames, addresses 10..15 drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) r_weights[k] <= '0;
      r_bias <= '0;
    end else if (Weight_Wr && (r_state == IDLE)) begin
      if (Weight_Addr == 4'(BIAS_ADDR)) begin
        r_bias <= Weight_In;
      end else if (Weight_Addr < 4'(NUM_TAPS)) begin
        r_weights[Weight_Addr] <= Weight_In;
      end
    end
  end

  // Bias aligned to the product Q format, then the 9-term adder tree
  always_comb begin
    w_sum = c_acc_w'(r_bias) <<< FRAC_BITS;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_sum = w_sum + c_acc_w'(r_prod[k]);
    end
  end

  // Round/saturate, with optional negative clamp
  always_comb begin
    w_res = DATA_WIDTH'(round_sat(SAT_W'(r_acc), FRAC_BITS, DATA_WIDTH));
`ifdef CONV2D_RELU_EN
    w_out = w_res[DATA_WIDTH-1] ? '0 : w_res;
`else
    w_out = w_res;
`endif
  end

  // MAC pipeline: products, accumulate, output; valid and last tags ride along
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) r_prod[k] <= '0;
      r_v2       <= 1'b0;
      r_l2       <= 1'b0;
      r_acc      <= '0;
      r_v3       <= 1'b0;
      r_l3       <= 1'b0;
      Data_Out   <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_prod[k] <= $signed(w_taps[k]) * r_weights[k];
      end
      r_v2       <= w_win_valid;
      r_l2       <= w_win_last;
      r_acc      <= w_sum;
      r_v3       <= r_v2;
      r_l3       <= r_l2;
      Valid_Out  <= r_v3;
      Frame_Done <= r_l3;
      if (r_v3) begin
        Data_Out <= w_out;
      end
    end
  end

  // Frame-tracking next state; a pixel seen while draining queues a new frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (Valid_In) w_next = FILL;
      FILL:  begin
        if (w_frame_end)    w_next = DRAIN;
        else if (w_row_ge2) w_next = RUN;
      end
      RUN:   if (w_frame_end) w_next = DRAIN;
      DRAIN: begin
        if (r_drain_cnt == 2'd2) w_next = (r_pending || Valid_In) ? FILL : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register plus drain timer and next-frame-pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      r_pending   <= (r_state == DRAIN && w_next == DRAIN) ? (r_pending | Valid_In) : 1'b0;
    end
  end

endmodule

`default_nettype wire
